// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debouncer.
//   debounce_state_t        : FSM state encoding used by the debouncer top.
//   DEBOUNCE_SYNC_STAGES    : default synchronizer depth.
//   DEBOUNCE_STABLE_CYCLES  : default number of settled samples needed to move out.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW,
    ST_WAIT_HIGH,
    ST_HIGH,
    ST_WAIT_LOW
  } debounce_state_t;

  localparam int DEBOUNCE_SYNC_STAGES   = 2;
  localparam int DEBOUNCE_STABLE_CYCLES = 16;

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit.
//   clk : destination clock
//   rst : asynchronous active-low reset, clears every stage
//   d   : asynchronous input
//   q   : synchronized output (last stage of the chain)
module synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s <= '0;
    end else begin
      s <= {s[STAGES-2:0], d};
    end
  end

  assign q = s[STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Debouncer: turns a raw, bouncing asynchronous input into a clean level that
// only changes after STABLE_CYCLES consecutive synchronized samples at the new
// level.
//   clk  : single clock, rising edge
//   rst  : asynchronous active-low reset
//   in   : raw asynchronous input
//   out  : debounced level, registered
//   busy : high while a candidate transition is being qualified, registered
module debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEBOUNCE_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic            sync_in;
  debounce_state_t state;
  logic [CNT_W-1:0] cnt;

  synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (in),
    .q  (sync_in)
  );

  // out/busy are assigned alongside the next state so they move on the same
  // edge as the state. cnt holds the number of samples already seen at the
  // candidate level; a single old-level sample discards all of it, and
  // rejection is checked before completion so it wins a tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_LOW;
      cnt   <= '0;
      out   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_LOW: begin
          if (sync_in) begin
            state <= ST_WAIT_HIGH;
            cnt   <= CNT_ONE;
            out   <= 1'b0;
            busy  <= 1'b1;
          end else begin
            cnt   <= '0;
            out   <= 1'b0;
            busy  <= 1'b0;
          end
        end
        ST_WAIT_HIGH: begin
          if (!sync_in) begin
            state <= ST_LOW;
            cnt   <= '0;
            out   <= 1'b0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_HIGH;
            cnt   <= '0;
            out   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt   <= cnt + CNT_ONE;
            out   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (!sync_in) begin
            state <= ST_WAIT_LOW;
            cnt   <= CNT_ONE;
            out   <= 1'b1;
            busy  <= 1'b1;
          end else begin
            cnt   <= '0;
            out   <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_WAIT_LOW: begin
          if (sync_in) begin
            state <= ST_HIGH;
            cnt   <= '0;
            out   <= 1'b1;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_LOW;
            cnt   <= '0;
            out   <= 1'b0;
            busy  <= 1'b0;
          end else begin
            cnt   <= cnt + CNT_ONE;
            out   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= ST_LOW;
          cnt   <= '0;
          out   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debouncer.sv
// Testbench for debouncer: two instances (defaults, and SYNC_STAGES=3 /
// STABLE_CYCLES=2) driven by the same stimulus. A reference model based on
// run lengths of delayed input samples predicts {out,busy} per edge; the
// monitors compare the DUT outputs against the queued predictions.
module tb_debouncer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in  = 1'b0;
  logic out_a, busy_a, out_b, busy_b;

  always #5 clk = ~clk;

  debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(16)) dut_a (
    .clk(clk), .rst(rst), .in(in), .out(out_a), .busy(busy_a)
  );

  debouncer #(.SYNC_STAGES(3), .STABLE_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .in(in), .out(out_b), .busy(busy_b)
  );

  int sync_n[2]   = '{2, 3};
  int stable_n[2] = '{16, 2};

  // Reference model state: samples of in still travelling through the
  // synchronizer, the current run of identical synchronized samples, and out.
  bit         dly[2][$];
  bit         run_val[2];
  int         run_len[2];
  bit         m_out[2];
  logic [1:0] exp_q[2][$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got {out,busy}=%b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int id);
    dly[id].delete();
    for (int k = 0; k < sync_n[id]; k++) dly[id].push_back(1'b0);
    run_val[id] = 1'b0;
    run_len[id] = 0;
    m_out[id]   = 1'b0;
  endtask

  // One rising edge with input level d: the synchronized sample seen by the
  // edge is the level captured sync_n edges earlier. out follows a level once
  // stable_n consecutive samples of it have been seen; busy marks a run at a
  // level different from out that has not qualified yet.
  task automatic model_step(input int id, input bit d);
    bit x;
    x = dly[id].pop_front();
    dly[id].push_back(d);
    if (x == run_val[id]) begin
      if (run_len[id] < 1000) run_len[id]++;
    end else begin
      run_val[id] = x;
      run_len[id] = 1;
    end
    if (x != m_out[id] && run_len[id] >= stable_n[id]) m_out[id] = x;
    exp_q[id].push_back({m_out[id], (x != m_out[id])});
  endtask

  // Drive one cycle at the falling edge; reset assertion is checked at once,
  // before any clock edge.
  task automatic cycle(input bit d, input bit r);
    @(negedge clk);
    in  = d;
    rst = r;
    if (!r) begin
      #1;
      check("rst_async_a", {out_a, busy_a}, 2'b00);
      check("rst_async_b", {out_b, busy_b}, 2'b00);
      for (int id = 0; id < 2; id++) begin
        model_reset(id);
        exp_q[id].push_back(2'b00);
      end
    end else begin
      for (int id = 0; id < 2; id++) model_step(id, d);
    end
  endtask

  task automatic hold(input bit d, input int n);
    for (int k = 0; k < n; k++) cycle(d, 1'b1);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q[0].size() > 0) check("dut_a", {out_a, busy_a}, exp_q[0].pop_front());
    if (exp_q[1].size() > 0) check("dut_b", {out_b, busy_b}, exp_q[1].pop_front());
  end

  initial begin
    bit lvl;
    int len;
    model_reset(0);
    model_reset(1);

    // Reset with in already high, then a normal rising qualification.
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    hold(1'b1, 25);

    // Clean release, press held 40 cycles, release.
    hold(1'b0, 25);
    hold(1'b1, 40);
    hold(1'b0, 25);

    // Glitch threshold: 15 samples rejected, 16 accepted.
    hold(1'b1, 15);
    hold(1'b0, 25);
    hold(1'b1, 16);
    hold(1'b0, 25);

    // Bounce train then settle high.
    for (int i = 0; i < 30; i++) cycle(((i / 3) % 2) == 0, 1'b1);
    hold(1'b1, 25);
    hold(1'b0, 25);

    // Reset mid-qualification with in held high, then full latency again.
    hold(1'b1, 12);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    hold(1'b1, 25);
    hold(1'b0, 25);

    // Short pulses around the small-parameter instance's threshold.
    hold(1'b1, 1);
    hold(1'b0, 8);
    hold(1'b1, 2);
    hold(1'b0, 8);
    hold(1'b1, 3);
    hold(1'b0, 25);

    // Random runs with occasional asynchronous reset.
    lvl = 1'b0;
    for (int r = 0; r < 150; r++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 399) == 0) cycle(lvl, 1'b0);
        else cycle(lvl, 1'b1);
      end
    end
    hold(1'b0, 25);

    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
